// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder front end: synchronizer, debounce filter, detent/direction
// decode and signed step counter. Define ROTARY_SAT_EN to saturate position instead of wrapping.
module rotary_decoder #(
   parameter int WIDTH      = 16,
   parameter int DEB_CYCLES = 4,
   parameter int MODE       = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r_a,
   input  logic             r_b,
   input  logic             clr,
   output logic             r_event,
   output logic             r_dir,
   output logic             step_valid,
   output logic             step_dir,
   output logic [WIDTH-1:0] position
);

   localparam logic [7:0]       DEB_LAST = 8'(DEB_CYCLES);
   localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1);
`ifdef ROTARY_SAT_EN
   localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] POS_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_filt;
   logic [1:0]       r_cand;
   logic [7:0]       r_cnt;
   logic             r_event_d;

   logic [7:0]       w_cnt_inc;
   logic             w_new_cand;
   logic             w_accept;
   logic             w_step;
   logic             w_step_dir;
   logic [WIDTH-1:0] w_pos_step;

   // Accept the candidate pair once it has differed from the filtered pair for DEB_CYCLES edges.
   always_comb begin
      w_cnt_inc  = r_cnt + 8'd1;
      w_new_cand = (r_sync2 != r_cand);
      if (r_sync2 == r_filt) begin
         w_accept = 1'b0;
      end else if (w_new_cand) begin
         w_accept = (DEB_LAST == 8'd1);
      end else begin
         w_accept = (w_cnt_inc == DEB_LAST);
      end
   end

   // Synchronizer, debounce counter and detent/direction decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
         r_filt  <= 2'b00;
         r_cand  <= 2'b00;
         r_cnt   <= 8'd0;
         r_event <= 1'b0;
         r_dir   <= 1'b0;
      end else begin
         r_sync1 <= {r_a, r_b};
         r_sync2 <= r_sync1;
         if (r_sync2 == r_filt) begin
            r_cnt <= 8'd0;
         end else if (w_accept) begin
            r_cnt  <= 8'd0;
            r_filt <= r_sync2;
            r_cand <= r_sync2;
         end else if (w_new_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= 8'd1;
         end else begin
            r_cnt <= w_cnt_inc;
         end
         if (w_accept) begin
            case (r_sync2)
               2'b11:   r_event <= 1'b1;
               2'b00:   r_event <= 1'b0;
               2'b01:   r_dir   <= 1'b1;
               2'b10:   r_dir   <= 1'b0;
               default: r_event <= r_event;
            endcase
         end
      end
   end

   // In two-step mode the falling detent edge follows the opposite phase, so its direction flips.
   always_comb begin
      if (MODE == 1) begin
         w_step     = r_event ^ r_event_d;
         w_step_dir = r_event ? r_dir : ~r_dir;
      end else begin
         w_step     = r_event & ~r_event_d;
         w_step_dir = r_dir;
      end
   end

   // Next position for a step in the current direction.
   always_comb begin
`ifdef ROTARY_SAT_EN
      if (w_step_dir && (position == POS_MAX)) begin
         w_pos_step = position;
      end else if (!w_step_dir && (position == POS_MIN)) begin
         w_pos_step = position;
      end else if (w_step_dir) begin
         w_pos_step = position + POS_ONE;
      end else begin
         w_pos_step = position - POS_ONE;
      end
`else
      if (w_step_dir) begin
         w_pos_step = position + POS_ONE;
      end else begin
         w_pos_step = position - POS_ONE;
      end
`endif
   end

   // Step strobe and position counter; clear wins over a coincident step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_event_d  <= 1'b0;
         step_valid <= 1'b0;
         step_dir   <= 1'b0;
         position   <= '0;
      end else begin
         r_event_d  <= r_event;
         step_valid <= w_step;
         if (w_step) begin
            step_dir <= w_step_dir;
         end
         if (clr) begin
            position <= '0;
         end else if (w_step) begin
            position <= w_pos_step;
         end
      end
   end

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed self-checking bench for rotary_decoder: three instances (MODE 0, MODE 1, WIDTH 4)
// share the pin stimulus; each scenario task checks the instance it targets.
module tb_rotary_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        pin_a = 1'b0;
   logic        pin_b = 1'b0;
   logic        clr = 1'b0;

   logic        ev0, dir0, sv0, sd0;
   logic [15:0] pos0;
   logic        ev1, dir1, sv1, sd1;
   logic [15:0] pos1;
   logic        ev2, dir2, sv2, sd2;
   logic [3:0]  pos2;

   int          errors = 0;
   int          checks = 0;
   int          cnt0, cnt1, cnt2, adj;
   logic        prev0, prev1, prev2;

   always #5 clk = ~clk;

   rotary_decoder #(.WIDTH(16), .DEB_CYCLES(4), .MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .r_a(pin_a), .r_b(pin_b), .clr(clr),
      .r_event(ev0), .r_dir(dir0), .step_valid(sv0), .step_dir(sd0), .position(pos0));

   rotary_decoder #(.WIDTH(16), .DEB_CYCLES(4), .MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .r_a(pin_a), .r_b(pin_b), .clr(clr),
      .r_event(ev1), .r_dir(dir1), .step_valid(sv1), .step_dir(sd1), .position(pos1));

   rotary_decoder #(.WIDTH(4), .DEB_CYCLES(4), .MODE(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .r_a(pin_a), .r_b(pin_b), .clr(clr),
      .r_event(ev2), .r_dir(dir2), .step_valid(sv2), .step_dir(sd2), .position(pos2));

   task automatic clear_counts();
      cnt0 = 0; cnt1 = 0; cnt2 = 0; adj = 0;
      prev0 = 1'b0; prev1 = 1'b0; prev2 = 1'b0;
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sv0) cnt0++;
         if (sv1) cnt1++;
         if (sv2) cnt2++;
         if ((sv0 && prev0) || (sv1 && prev1) || (sv2 && prev2)) adj++;
         prev0 = sv0; prev1 = sv1; prev2 = sv2;
      end
   endtask

   task automatic set_pins(input logic a, input logic b);
      pin_a = a;
      pin_b = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_pins(1'b0, 1'b0);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      clear_counts();
   endtask

   task automatic detent_cw();
      set_pins(1'b0, 1'b1); hold(10);
      set_pins(1'b1, 1'b1); hold(10);
      set_pins(1'b1, 1'b0); hold(10);
      set_pins(1'b0, 1'b0); hold(10);
   endtask

   task automatic detent_ccw();
      set_pins(1'b1, 1'b0); hold(10);
      set_pins(1'b1, 1'b1); hold(10);
      set_pins(1'b0, 1'b1); hold(10);
      set_pins(1'b0, 1'b0); hold(10);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ev0, dir0, sv0, sd0} !== 4'b0000 || pos0 !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got ev=%b dir=%b sv=%b sd=%b pos=%0d expected all 0", ev0, dir0, sv0, sd0, pos0);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_latency();
      int first;
      int n;
      logic dir_at;
      logic [15:0] pos_before;
      logic [15:0] pos_at;
      do_reset();
      first = 0; n = 0; dir_at = 1'b0; pos_before = 16'hDEAD; pos_at = 16'hDEAD;
      set_pins(1'b0, 1'b1); hold(10);
      set_pins(1'b1, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 6) pos_before = pos0;
         if (sv0) begin
            n++;
            if (first == 0) begin
               first = k; dir_at = sd0; pos_at = pos0;
            end
         end
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL lat_pulse_count: got %0d expected 1", n); end
      checks++; if (first !== 7) begin errors++; $display("FAIL lat_edge: got %0d expected 7", first); end
      checks++; if (dir_at !== 1'b1) begin errors++; $display("FAIL lat_step_dir: got %b expected 1", dir_at); end
      checks++; if (pos_before !== 16'd0) begin errors++; $display("FAIL lat_pos_before: got %0d expected 0", pos_before); end
      checks++; if (pos_at !== 16'd1) begin errors++; $display("FAIL lat_pos_at: got %0d expected 1", pos_at); end
      checks++; if ({ev0, dir0} !== 2'b11) begin errors++; $display("FAIL lat_event_dir: got %b%b expected 11", ev0, dir0); end
   endtask

   task automatic test_ccw_mode0();
      do_reset();
      set_pins(1'b1, 1'b0); hold(10);
      set_pins(1'b1, 1'b1); hold(10);
      checks++; if (pos0 !== 16'hFFFF) begin errors++; $display("FAIL ccw_pos: got %h expected ffff", pos0); end
      checks++; if (dir0 !== 1'b0) begin errors++; $display("FAIL ccw_dir: got %b expected 0", dir0); end
      set_pins(1'b0, 1'b0); hold(10);
      checks++; if (cnt0 !== 1) begin errors++; $display("FAIL ccw_pulses: got %0d expected 1", cnt0); end
      checks++; if (ev0 !== 1'b0) begin errors++; $display("FAIL ccw_event_fall: got %b expected 0", ev0); end
   endtask

   task automatic test_glitch();
      do_reset();
      set_pins(1'b1, 1'b1); hold(3);
      set_pins(1'b0, 1'b0); hold(15);
      checks++; if (cnt0 !== 0 || cnt1 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d/%0d expected 0/0", cnt0, cnt1); end
      checks++; if (ev0 !== 1'b0) begin errors++; $display("FAIL glitch_event: got %b expected 0", ev0); end
      checks++; if (pos0 !== 16'd0) begin errors++; $display("FAIL glitch_pos: got %0d expected 0", pos0); end
   endtask

   task automatic test_mode1();
      do_reset();
      repeat (4) detent_cw();
      checks++; if (cnt1 !== 8) begin errors++; $display("FAIL m1_cw_pulses: got %0d expected 8", cnt1); end
      checks++; if (pos1 !== 16'd8) begin errors++; $display("FAIL m1_cw_pos: got %0d expected 8", pos1); end
      checks++; if (pos0 !== 16'd4) begin errors++; $display("FAIL m0_cw_pos: got %0d expected 4", pos0); end
      repeat (4) detent_ccw();
      checks++; if (cnt1 !== 16) begin errors++; $display("FAIL m1_ccw_pulses: got %0d expected 16", cnt1); end
      checks++; if (pos1 !== 16'd0) begin errors++; $display("FAIL m1_ccw_pos: got %0d expected 0", pos1); end
      checks++; if (pos0 !== 16'd0) begin errors++; $display("FAIL m0_ccw_pos: got %0d expected 0", pos0); end
      checks++; if (adj !== 0) begin errors++; $display("FAIL adjacent_pulses: got %0d expected 0", adj); end
   endtask

   task automatic test_clr();
      do_reset();
      repeat (5) detent_cw();
      checks++; if (pos0 !== 16'd5) begin errors++; $display("FAIL clr_pre_pos: got %0d expected 5", pos0); end
      set_pins(1'b0, 1'b1); hold(10);
      set_pins(1'b1, 1'b1);
      repeat (6) @(negedge clk);
      checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL clr_early_step: got %b expected 0", sv0); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checks++; if (sv0 !== 1'b1) begin errors++; $display("FAIL clr_step_valid: got %b expected 1", sv0); end
      checks++; if (pos0 !== 16'd0) begin errors++; $display("FAIL clr_pos: got %0d expected 0", pos0); end
      hold(10);
      set_pins(1'b1, 1'b0); hold(10);
      set_pins(1'b0, 1'b0); hold(10);
      detent_cw();
      checks++; if (pos0 !== 16'd1) begin errors++; $display("FAIL clr_post_pos: got %0d expected 1", pos0); end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_pos2;
`ifdef ROTARY_SAT_EN
      exp_pos2 = 4'd7;
`else
      exp_pos2 = 4'd8;
`endif
      do_reset();
      repeat (7) detent_cw();
      checks++; if (pos2 !== 4'd7) begin errors++; $display("FAIL w4_pos7: got %0d expected 7", pos2); end
      detent_cw();
      checks++; if (pos2 !== exp_pos2) begin errors++; $display("FAIL w4_boundary: got %0d expected %0d", pos2, exp_pos2); end
      checks++; if (cnt2 !== 8) begin errors++; $display("FAIL w4_pulses: got %0d expected 8", cnt2); end
      checks++; if (pos0 !== 16'd8) begin errors++; $display("FAIL w16_pos8: got %0d expected 8", pos0); end
   endtask

   task automatic test_reset_mid();
      int first;
      int n;
      do_reset();
      set_pins(1'b0, 1'b1); hold(10);
      set_pins(1'b1, 1'b1); hold(10);
      set_pins(1'b0, 1'b0); hold(3);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ev0, dir0, sv0, sd0} !== 4'b0000 || pos0 !== 16'd0 || pos1 !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: got ev=%b dir=%b sv=%b sd=%b pos0=%0d pos1=%0d expected all 0", ev0, dir0, sv0, sd0, pos0, pos1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_counts();
      hold(20);
      checks++; if (cnt0 !== 0 || cnt1 !== 0) begin errors++; $display("FAIL discard_pending: got %0d/%0d expected 0/0", cnt0, cnt1); end
      set_pins(1'b1, 1'b1); hold(4);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ev0, sv0} !== 2'b00 || pos0 !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_debounce: got ev=%b sv=%b pos=%0d expected 0", ev0, sv0, pos0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first = 0; n = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (sv0) begin
            n++;
            if (first == 0) first = k;
         end
      end
      checks++; if (first !== 7) begin errors++; $display("FAIL post_reset_edge: got %0d expected 7", first); end
      checks++; if (n !== 1) begin errors++; $display("FAIL post_reset_pulses: got %0d expected 1", n); end
   endtask

   initial begin
      clear_counts();
      test_reset();
      test_latency();
      test_ccw_mode0();
      test_glitch();
      test_mode1();
      test_clr();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
